// File: rtl/mtr_drv_pkg.sv
// Shared constants and helpers for the multi-channel H-bridge motor driver.
package mtr_drv_pkg;

  localparam int W_DEF    = 11;
  localparam int SLEW_DEF = 64;
  localparam int DEAD_DEF = 4;

  typedef logic [W_DEF-1:0] duty_t;

  // Offset-binary zero point: the duty that represents a commanded speed of 0.
  function automatic logic [31:0] mid_duty(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/mtr_pwm_ch.sv
// One motor channel: boundary-gated slew-limited duty, PWM compare and
// dead-time insertion on the complementary pair.
module mtr_pwm_ch
  import mtr_drv_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int SLEW = SLEW_DEF,
  parameter int DEAD = DEAD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bnd,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] spd,
  output logic         pwm_p,
  output logic         pwm_n,
  output logic [W-1:0] duty_q
);

  localparam logic [W-1:0]        MID    = W'(mid_duty(W));
  localparam logic signed [W:0]   SLEW_S = (W+1)'(SLEW);
  localparam logic [W-1:0]        SLEW_U = W'(SLEW);
  localparam logic [7:0]          DEAD_C = 8'(DEAD);

  logic [W-1:0]      duty;
  logic [W-1:0]      tgt;
  logic [W-1:0]      duty_nxt;
  logic signed [W:0] diff;
  logic              raw_p;
  logic              raw_n;
  logic [7:0]        dc_p;
  logic [7:0]        dc_n;

  // Signed speed to offset-binary duty is just an MSB flip.
  assign tgt  = {~spd[W-1], spd[W-2:0]};
  assign diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});

  always_comb begin
    duty_nxt = tgt;
    if (diff > SLEW_S)
      duty_nxt = duty + SLEW_U;
    else if (diff < -SLEW_S)
      duty_nxt = duty - SLEW_U;
  end

  assign raw_p = (cnt < duty);
  assign raw_n = ~raw_p;

  // A dead counter that has reached DEAD means its raw level has been high
  // long enough for the opposite switch to have turned off.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      duty  <= MID;
      dc_p  <= 8'd0;
      dc_n  <= 8'd0;
      pwm_p <= 1'b0;
      pwm_n <= 1'b0;
    end else begin
      if (bnd)
        duty <= duty_nxt;
      dc_p  <= raw_p ? ((dc_p == DEAD_C) ? dc_p : dc_p + 8'd1) : 8'd0;
      dc_n  <= raw_n ? ((dc_n == DEAD_C) ? dc_n : dc_n + 8'd1) : 8'd0;
      pwm_p <= raw_p && (dc_p == DEAD_C);
      pwm_n <= raw_n && (dc_n == DEAD_C);
    end
  end

  assign duty_q = duty;

endmodule

// File: rtl/mtr_drv_ch.sv
// Multi-channel H-bridge driver: shared period counter and boundary strobe,
// one mtr_pwm_ch per motor channel.
module mtr_drv_ch
  import mtr_drv_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int W    = W_DEF,
  parameter int SLEW = SLEW_DEF,
  parameter int DEAD = DEAD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH*W-1:0] spd,
  output logic [NCH-1:0]   pwm_p,
  output logic [NCH-1:0]   pwm_n,
  output logic [NCH*W-1:0] duty_q,
  output logic             prd_strb
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_PRE = CNT_MAX - W'(1);

  logic [W-1:0] cnt;
  logic         bnd;

  assign bnd = (cnt == CNT_MAX);

  // prd_strb is registered one cycle early so it lines up with cnt == max.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      prd_strb <= 1'b0;
    end else begin
      cnt      <= cnt + W'(1);
      prd_strb <= (cnt == CNT_PRE);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mtr_pwm_ch #(
      .W    (W),
      .SLEW (SLEW),
      .DEAD (DEAD)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .bnd    (bnd),
      .cnt    (cnt),
      .spd    (spd[i*W +: W]),
      .pwm_p  (pwm_p[i]),
      .pwm_n  (pwm_n[i]),
      .duty_q (duty_q[i*W +: W])
    );
  end

endmodule

// File: tb/tb_mtr_drv_ch.sv
// Bench for mtr_drv_ch: behavioural period/slew/dead-time model plus scenarios.
module tb_mtr_drv_ch;

  localparam int NCH  = 2;
  localparam int W    = 11;
  localparam int SLEW = 64;
  localparam int DEAD = 4;
  localparam int PER  = 1 << W;
  localparam int MID  = 1 << (W - 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NCH*W-1:0] spd;
  logic [NCH-1:0]   pwm_p;
  logic [NCH-1:0]   pwm_n;
  logic [NCH*W-1:0] duty_q;
  logic             prd_strb;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: period position, applied duty and the length of
  // the current unbroken run of each effective raw level.
  int             m_cnt = 0;
  int             m_duty[NCH];
  int             run_p[NCH];
  int             run_n[NCH];
  logic [NCH-1:0] e_p;
  logic [NCH-1:0] e_n;
  logic           e_strb;

  mtr_drv_ch #(.NCH(NCH), .W(W), .SLEW(SLEW), .DEAD(DEAD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .spd      (spd),
    .pwm_p    (pwm_p),
    .pwm_n    (pwm_n),
    .duty_q   (duty_q),
    .prd_strb (prd_strb)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH*W-1:0] e_duty();
    logic [NCH*W-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*W +: W] = W'(m_duty[i]);
    return v;
  endfunction

  // Advance model and DUT by one clock; outputs are valid #1 after the edge.
  task automatic tick();
    int nxt;
    for (int i = 0; i < NCH; i++) begin
      int s;
      int tgt;
      bit raw;
      raw = (m_cnt < m_duty[i]);
      run_p[i] = (!rst && en && raw)  ? run_p[i] + 1 : 0;
      run_n[i] = (!rst && en && !raw) ? run_n[i] + 1 : 0;
      e_p[i] = (run_p[i] > DEAD);
      e_n[i] = (run_n[i] > DEAD);
      if (rst || !en) begin
        m_duty[i] = MID;
      end else if (m_cnt == PER - 1) begin
        s   = $signed(spd[i*W +: W]);
        tgt = s + MID;
        if (tgt > m_duty[i] + SLEW)      m_duty[i] = m_duty[i] + SLEW;
        else if (tgt < m_duty[i] - SLEW) m_duty[i] = m_duty[i] - SLEW;
        else                             m_duty[i] = tgt;
      end
    end
    nxt    = rst ? 0 : (m_cnt + 1) % PER;
    e_strb = !rst && (nxt == PER - 1);
    @(posedge clk);
    #1;
    m_cnt = nxt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    spd = '0;
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = MID;
      run_p[i]  = 0;
      run_n[i]  = 0;
    end
    tick();
    tick();
    n_cmp++;
    if ({pwm_p, pwm_n, prd_strb} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got p=%b n=%b s=%b want all 0", pwm_p, pwm_n, prd_strb);
    end
    n_cmp++;
    if (duty_q !== {11'd1024, 11'd1024}) begin
      n_err++;
      $display("FAIL reset_duty got %h want %h", duty_q, {11'd1024, 11'd1024});
    end
    rst = 1'b0;
  endtask

  task automatic test_midpoint();
    int hp, hn, ov, st;
    repeat (PER) begin
      tick();
      n_cmp++;
      if ({pwm_p, pwm_n, prd_strb, duty_q} !== {e_p, e_n, e_strb, e_duty()}) begin
        n_err++;
        $display("FAIL mid_cycle cnt=%0d got %h want %h", m_cnt,
                 {pwm_p, pwm_n, prd_strb, duty_q}, {e_p, e_n, e_strb, e_duty()});
      end
    end
    hp = 0; hn = 0; ov = 0; st = 0;
    repeat (PER) begin
      tick();
      hp += int'(pwm_p[0]);
      hn += int'(pwm_n[0]);
      ov += int'((pwm_p & pwm_n) != '0);
      st += int'(prd_strb);
    end
    n_cmp++;
    if (hp !== 1020 || hn !== 1020) begin
      n_err++;
      $display("FAIL mid_high_count got p=%0d n=%0d want 1020/1020", hp, hn);
    end
    n_cmp++;
    if (ov !== 0 || st !== 1) begin
      n_err++;
      $display("FAIL mid_overlap_strb got overlap=%0d strb=%0d want 0/1", ov, st);
    end
  endtask

  task automatic test_slew_up();
    spd[0 +: W] = 11'd512;
    for (int p = 1; p <= 8; p++) begin
      repeat (PER) begin
        tick();
        n_cmp++;
        if ({pwm_p, pwm_n, prd_strb, duty_q} !== {e_p, e_n, e_strb, e_duty()}) begin
          n_err++;
          $display("FAIL up_cycle cnt=%0d got %h want %h", m_cnt,
                   {pwm_p, pwm_n, prd_strb, duty_q}, {e_p, e_n, e_strb, e_duty()});
        end
      end
      n_cmp++;
      if (duty_q !== {11'd1024, 11'(1024 + 64 * p)}) begin
        n_err++;
        $display("FAIL up_period%0d got %h want %h", p, duty_q, {11'd1024, 11'(1024 + 64 * p)});
      end
    end
  endtask

  task automatic test_slew_down();
    int hp, hn;
    spd[W +: W] = 11'h400;
    for (int p = 1; p <= 16; p++) begin
      repeat (PER) begin
        tick();
        n_cmp++;
        if ({pwm_p, pwm_n, prd_strb, duty_q} !== {e_p, e_n, e_strb, e_duty()}) begin
          n_err++;
          $display("FAIL down_cycle cnt=%0d got %h want %h", m_cnt,
                   {pwm_p, pwm_n, prd_strb, duty_q}, {e_p, e_n, e_strb, e_duty()});
        end
      end
      n_cmp++;
      if (duty_q !== {11'(1024 - 64 * p), 11'd1536}) begin
        n_err++;
        $display("FAIL down_period%0d got %h want %h", p, duty_q, {11'(1024 - 64 * p), 11'd1536});
      end
    end
    hp = 0; hn = 0;
    repeat (PER) begin
      tick();
      hp += int'(pwm_p[1]);
      hn += int'(pwm_n[1]);
    end
    n_cmp++;
    if (hp !== 0 || hn !== PER) begin
      n_err++;
      $display("FAIL down_zero_duty got p=%0d n=%0d want 0/%0d", hp, hn, PER);
    end
  endtask

  task automatic test_mid_period();
    logic [NCH*W-1:0] saved, d0;
    saved = spd;
    d0    = duty_q;
    for (int t = 0; t < PER; t++) begin
      if (m_cnt == 500)  spd = NCH*W'($urandom);
      if (m_cnt == 1500) spd = saved;
      tick();
      n_cmp++;
      if ({pwm_p, pwm_n, prd_strb, duty_q} !== {e_p, e_n, e_strb, e_duty()}) begin
        n_err++;
        $display("FAIL midchg_cycle cnt=%0d got %h want %h", m_cnt,
                 {pwm_p, pwm_n, prd_strb, duty_q}, {e_p, e_n, e_strb, e_duty()});
      end
    end
    n_cmp++;
    if (duty_q !== d0) begin
      n_err++;
      $display("FAIL midchg_duty got %h want %h", duty_q, d0);
    end
  endtask

  task automatic test_enable();
    while (m_cnt != 300) tick();
    n_cmp++;
    if (duty_q[0 +: W] !== 11'd1536) begin
      n_err++;
      $display("FAIL en_pre_duty got %0d want 1536", duty_q[0 +: W]);
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if ({pwm_p, pwm_n} !== '0 || duty_q !== {11'd1024, 11'd1024}) begin
      n_err++;
      $display("FAIL en_off got p=%b n=%b d=%h want 0/0/%h", pwm_p, pwm_n, duty_q, {11'd1024, 11'd1024});
    end
    for (int t = 0; t < 2000; t++) begin
      if (t == 200) en = 1'b1;
      tick();
      n_cmp++;
      if ({pwm_p, pwm_n, prd_strb, duty_q} !== {e_p, e_n, e_strb, e_duty()}) begin
        n_err++;
        $display("FAIL en_cycle cnt=%0d got %h want %h", m_cnt,
                 {pwm_p, pwm_n, prd_strb, duty_q}, {e_p, e_n, e_strb, e_duty()});
      end
      if (m_cnt == 0) break;
    end
    n_cmp++;
    if (duty_q !== {11'd960, 11'd1088}) begin
      n_err++;
      $display("FAIL en_resume got %h want %h", duty_q, {11'd960, 11'd1088});
    end
  endtask

  task automatic test_reset_mid();
    int k;
    while (m_cnt != 100) tick();
    n_cmp++;
    if (pwm_p[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre got pwm_p0=%b want 1", pwm_p[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({pwm_p, pwm_n, prd_strb} !== '0 || duty_q !== {11'd1024, 11'd1024}) begin
      n_err++;
      $display("FAIL rstmid_out got p=%b n=%b s=%b d=%h", pwm_p, pwm_n, prd_strb, duty_q);
    end
    k = 0;
    while (k < 2100) begin
      tick();
      k++;
      if (prd_strb === 1'b1) break;
    end
    n_cmp++;
    if (k !== PER - 1) begin
      n_err++;
      $display("FAIL rstmid_strb got first strobe after %0d cycles want %0d", k, PER - 1);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3 * PER; t++) begin
      if ($urandom_range(0, 299) == 0) spd[$urandom_range(0, NCH-1)*W +: W] = W'($urandom_range(0, PER - 1));
      if ($urandom_range(0, 1499) == 0) en = ~en;
      tick();
      n_cmp++;
      if ({pwm_p, pwm_n, prd_strb, duty_q} !== {e_p, e_n, e_strb, e_duty()}) begin
        n_err++;
        $display("FAIL rand_cycle cnt=%0d got %h want %h", m_cnt,
                 {pwm_p, pwm_n, prd_strb, duty_q}, {e_p, e_n, e_strb, e_duty()});
      end
      n_cmp++;
      if ((pwm_p & pwm_n) !== '0) begin
        n_err++;
        $display("FAIL rand_overlap got p=%b n=%b want disjoint", pwm_p, pwm_n);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    spd = '0;
    test_reset();
    test_midpoint();
    test_slew_up();
    test_slew_down();
    test_mid_period();
    test_enable();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
